axis_to_bram_writer: RTL

AXIS_TO_BRAM_WRITER -- requirements
Module: axis_to_bram_writer

---
 rtl/axis_to_bram_writer.sv | 79 +++++++
 1 files changed

// File: rtl/axis_to_bram_writer.sv
// axis_to_bram_writer: AXI-Stream sink that writes one packet into consecutive BRAM words
// Ports: aclk / rst (sync, active-high); start arms a transfer from IDLE;
//   s_axis_* stream input, tready high only in RUN;
//   bram_* registered write port, one cycle behind the accepting edge;
//   busy (RUN), done (one-cycle FIN pulse), err (sticky tlast mismatch), words_written.
module axis_to_bram_writer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int BASE_ADDR  = 32768,
    parameter int WORD_COUNT = 4800
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_written
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [15:0]       LAST_IDX = 16'(WORD_COUNT - 1);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              accept, final_beat, arm;
    assign s_axis_tready = state == RUN;
    assign busy          = state == RUN;
    assign done          = state == FIN;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign final_beat    = words_written == LAST_IDX;
    assign arm           = state == IDLE && start;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = accept && (final_beat || s_axis_tlast) ? FIN : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge aclk) begin
        if (rst) begin
            ptr           <= BASE;
            words_written <= '0;
            err           <= 1'b0;
            bram_en       <= 1'b0;
            bram_we       <= 1'b0;
            bram_addr     <= BASE;
            bram_din      <= '0;
        end else begin
            bram_en <= accept;
            bram_we <= accept;
            if (arm) begin
                ptr           <= BASE;
                words_written <= '0;
                err           <= 1'b0;
            end
            if (accept) begin
                bram_addr     <= ptr;
                bram_din      <= s_axis_tdata;
                ptr           <= ptr + 1'b1;
                words_written <= words_written + 1'b1;
                // tlast must coincide exactly with the expected final beat
                if (final_beat != s_axis_tlast) err <= 1'b1;
            end
        end
    end
endmodule
